rf_wb_queue: RTL and testbench

Writer-side companion to the single-cycle register file: buffers results from the two writeback producers (ALU and memory stage) and retires them through the register file's single write port (dst_addr/dst/we), one per cycle, in program order. While results wait in the queue, it provides bypass lookup for the two read-port addresses so that decode sees pending values. Sits between the EX/MEM writeback paths and the register file.

---
 rtl/rf_pkg.sv | 21 ++
 rtl/rf_wb_queue_if.sv | 59 +++++
 rtl/rf_wbq_match.sv | 47 ++++
 rtl/rf_wb_queue.sv | 109 ++++++++++
 tb/tb_rf_wb_queue.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared register-file constants and the writeback entry type.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 16;
    localparam int NUM_REGS   = 16;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 4'h0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/rf_wb_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_queue_if
// Description : Producer, RF write-port and bypass-lookup signals of the
//               writeback queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_wb_queue_if
    import rf_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) ();

    logic              mem_vld;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_rdy;

    logic              alu_vld;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              alu_rdy;

    logic [ADDR_W-1:0] dst_addr;
    logic [DATA_W-1:0] dst;
    logic              we;

    logic [ADDR_W-1:0] p0_addr;
    logic [ADDR_W-1:0] p1_addr;
    logic              p0_hit;
    logic              p1_hit;
    logic [DATA_W-1:0] p0_byp;
    logic [DATA_W-1:0] p1_byp;

    logic              empty;

    modport slave (
        input  mem_vld, mem_addr, mem_data,
        input  alu_vld, alu_addr, alu_data,
        input  p0_addr, p1_addr,
        output mem_rdy, alu_rdy,
        output dst_addr, dst, we,
        output p0_hit, p1_hit, p0_byp, p1_byp,
        output empty
    );

    modport master (
        output mem_vld, mem_addr, mem_data,
        output alu_vld, alu_addr, alu_data,
        output p0_addr, p1_addr,
        input  mem_rdy, alu_rdy,
        input  dst_addr, dst, we,
        input  p0_hit, p1_hit, p0_byp, p1_byp,
        input  empty
    );

endinterface
`default_nettype wire

// File: rtl/rf_wbq_match.sv
`default_nettype none
// ============================================================================
// Module      : rf_wbq_match
// Description : Combinational youngest-match search over the queued entries.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wbq_match
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int CNT_W = 3
) (
    input  wb_entry_t             i_entries [DEPTH],
    input  logic [PTR_W-1:0]      i_head,
    input  logic [CNT_W-1:0]      i_count,
    input  logic [REG_ADDR_W-1:0] i_addr,
    output logic                  o_hit,
    output logic [REG_DATA_W-1:0] o_data
);

    logic [PTR_W-1:0] w_idx [DEPTH];
    logic [DEPTH-1:0] w_match;

    // Age slot k is the k-th oldest entry; only slots below count hold data.
    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_age
            assign w_idx[k]   = i_head + PTR_W'(k);
            assign w_match[k] = (CNT_W'(k) < i_count) &&
                                (i_entries[w_idx[k]].addr == i_addr) &&
                                (i_addr != REG_ZERO);
        end
    endgenerate

    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_match[k]) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_idx[k]].data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rf_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_queue
// Description : In-order writeback queue feeding the single RF write port,
//               with bypass lookup of pending results for two read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_queue
    import rf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    rf_wb_queue_if.slave  wb
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    wb_entry_t          r_entries [DEPTH];
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;

    logic               w_empty;
    logic               w_deq;
    logic [c_cnt_w:0]   w_free;
    logic               w_mem_rdy;
    logic               w_alu_rdy;
    logic               w_enq_mem;
    logic               w_enq_alu;
    logic [c_ptr_w-1:0] w_alu_slot;

    assign w_empty = (r_count == '0);
    assign w_deq   = !w_empty;

    // The head retires on every edge it is valid, so it credits one slot now.
    assign w_free = (c_cnt_w + 1)'(DEPTH) - {1'b0, r_count} + (c_cnt_w + 1)'(w_deq);

    assign w_mem_rdy = (w_free != '0);
    assign w_alu_rdy = wb.mem_vld ? (w_free >= (c_cnt_w + 1)'(2)) : (w_free != '0);

    // R0 writes complete the handshake but never take a slot.
    assign w_enq_mem  = wb.mem_vld && w_mem_rdy && (wb.mem_addr != REG_ZERO);
    assign w_enq_alu  = wb.alu_vld && w_alu_rdy && (wb.alu_addr != REG_ZERO);
    assign w_alu_slot = r_tail + c_ptr_w'(w_enq_mem);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            if (w_enq_mem) begin
                r_entries[r_tail] <= '{addr: wb.mem_addr, data: wb.mem_data};
            end
            if (w_enq_alu) begin
                r_entries[w_alu_slot] <= '{addr: wb.alu_addr, data: wb.alu_data};
            end
            if (w_deq) begin
                r_head <= r_head + c_ptr_w'(1);
            end
            r_tail  <= r_tail + c_ptr_w'(w_enq_mem) + c_ptr_w'(w_enq_alu);
            r_count <= r_count + c_cnt_w'(w_enq_mem) + c_cnt_w'(w_enq_alu)
                       - c_cnt_w'(w_deq);
        end
    end

    assign wb.we       = w_deq;
    assign wb.dst_addr = r_entries[r_head].addr;
    assign wb.dst      = r_entries[r_head].data;
    assign wb.empty    = w_empty;
    assign wb.mem_rdy  = w_mem_rdy;
    assign wb.alu_rdy  = w_alu_rdy;

    rf_wbq_match #(
        .DEPTH (DEPTH),
        .PTR_W (c_ptr_w),
        .CNT_W (c_cnt_w)
    ) u_match_p0 (
        .i_entries (r_entries),
        .i_head    (r_head),
        .i_count   (r_count),
        .i_addr    (wb.p0_addr),
        .o_hit     (wb.p0_hit),
        .o_data    (wb.p0_byp)
    );

    rf_wbq_match #(
        .DEPTH (DEPTH),
        .PTR_W (c_ptr_w),
        .CNT_W (c_cnt_w)
    ) u_match_p1 (
        .i_entries (r_entries),
        .i_head    (r_head),
        .i_count   (r_count),
        .i_addr    (wb.p1_addr),
        .o_hit     (wb.p1_hit),
        .o_data    (wb.p1_byp)
    );

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wb_queue
// Description : Directed vector table plus corner-case sequences for the
//               writeback queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_queue;

    logic clk;
    logic rst_n;

    int n_tests = 0;
    int n_fail  = 0;

    rf_wb_queue_if #(.DATA_W(16), .ADDR_W(4)) wb_if ();

    rf_wb_queue #(.DEPTH(4), .DATA_W(16), .ADDR_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mv; logic [3:0] ma; logic [15:0] md;
        logic        av; logic [3:0] aa; logic [15:0] ad;
        logic [3:0]  p0; logic [3:0] p1;
        logic        we; logic [3:0] da; logic [15:0] d;
        logic        emp; logic mr; logic ar;
        logic        h0; logic [15:0] b0;
        logic        h1; logic [15:0] b1;
    } vec_t;

    vec_t vecs [10];

    logic [3:0]  sb_addr [$];
    logic [15:0] sb_data [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mv, input logic [3:0] ma, input logic [15:0] md,
                         input logic av, input logic [3:0] aa, input logic [15:0] ad);
        wb_if.mem_vld  = mv; wb_if.mem_addr = ma; wb_if.mem_data = md;
        wb_if.alu_vld  = av; wb_if.alu_addr = aa; wb_if.alu_data = ad;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        wb_if.p0_addr = 0;
        wb_if.p1_addr = 0;

        // mv ma md  av aa ad  p0 p1  we da d  emp mr ar  h0 b0  h1 b1
        vecs[0] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 3, 0, 0, 0, 16'h0000, 1, 1, 1, 0, 16'h0000, 0, 16'h0000};
        vecs[1] = '{1, 3, 16'h1234, 0, 0, 16'h0000, 3, 0, 0, 0, 16'h0000, 1, 1, 1, 0, 16'h0000, 0, 16'h0000};
        vecs[2] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 3, 0, 1, 3, 16'h1234, 0, 1, 1, 1, 16'h1234, 0, 16'h0000};
        vecs[3] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 3, 0, 0, 0, 16'h0000, 1, 1, 1, 0, 16'h0000, 0, 16'h0000};
        vecs[4] = '{1, 5, 16'h0001, 1, 5, 16'h0002, 5, 5, 0, 0, 16'h0000, 1, 1, 1, 0, 16'h0000, 0, 16'h0000};
        vecs[5] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 5, 5, 1, 5, 16'h0001, 0, 1, 1, 1, 16'h0002, 1, 16'h0002};
        vecs[6] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 5, 5, 1, 5, 16'h0002, 0, 1, 1, 1, 16'h0002, 1, 16'h0002};
        vecs[7] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 5, 5, 0, 0, 16'h0000, 1, 1, 1, 0, 16'h0000, 0, 16'h0000};
        vecs[8] = '{0, 0, 16'h0000, 1, 0, 16'hFFFF, 0, 0, 0, 0, 16'h0000, 1, 1, 1, 0, 16'h0000, 0, 16'h0000};
        vecs[9] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 1, 1, 0, 16'h0000, 0, 16'h0000};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table: outputs are sampled before the edge that consumes the inputs.
        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            drive(vecs[v].mv, vecs[v].ma, vecs[v].md, vecs[v].av, vecs[v].aa, vecs[v].ad);
            wb_if.p0_addr = vecs[v].p0;
            wb_if.p1_addr = vecs[v].p1;
            #1;
            check($sformatf("v%0d_we", v),       wb_if.we,       vecs[v].we);
            check($sformatf("v%0d_dst_addr", v), wb_if.dst_addr, vecs[v].da);
            check($sformatf("v%0d_dst", v),      wb_if.dst,      vecs[v].d);
            check($sformatf("v%0d_empty", v),    wb_if.empty,    vecs[v].emp);
            check($sformatf("v%0d_mem_rdy", v),  wb_if.mem_rdy,  vecs[v].mr);
            check($sformatf("v%0d_alu_rdy", v),  wb_if.alu_rdy,  vecs[v].ar);
            check($sformatf("v%0d_p0_hit", v),   wb_if.p0_hit,   vecs[v].h0);
            check($sformatf("v%0d_p0_byp", v),   wb_if.p0_byp,   vecs[v].b0);
            check($sformatf("v%0d_p1_hit", v),   wb_if.p1_hit,   vecs[v].h1);
            check($sformatf("v%0d_p1_byp", v),   wb_if.p1_byp,   vecs[v].b1);
        end

        // Dual-producer burst: alu_rdy drops once the queue is full.
        begin
            logic exp_ardy [6];
            exp_ardy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
            wb_if.p0_addr = 0;
            wb_if.p1_addr = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                drive(1, 4'(c + 1), 16'h0100 + 16'(c), 1, 4'(c + 8), 16'h0200 + 16'(c));
                #1;
                check($sformatf("burst%0d_mem_rdy", c), wb_if.mem_rdy, 1);
                check($sformatf("burst%0d_alu_rdy", c), wb_if.alu_rdy, exp_ardy[c]);
                if (c >= 1) check($sformatf("burst%0d_we", c), wb_if.we, 1);
                if (wb_if.we) begin
                    if (sb_addr.size() == 0) begin
                        check($sformatf("burst%0d_spurious_we", c), wb_if.we, 0);
                    end else begin
                        check($sformatf("burst%0d_dst_addr", c), wb_if.dst_addr, sb_addr.pop_front());
                        check($sformatf("burst%0d_dst", c),      wb_if.dst,      sb_data.pop_front());
                    end
                end
                if (wb_if.mem_rdy) begin
                    sb_addr.push_back(4'(c + 1));
                    sb_data.push_back(16'h0100 + 16'(c));
                end
                if (wb_if.alu_rdy) begin
                    sb_addr.push_back(4'(c + 8));
                    sb_data.push_back(16'h0200 + 16'(c));
                end
            end
            for (int k = 0; k < 20 && sb_addr.size() > 0; k++) begin
                @(negedge clk);
                drive(0, 0, 0, 0, 0, 0);
                #1;
                check($sformatf("drain%0d_we", k),       wb_if.we,       1);
                check($sformatf("drain%0d_dst_addr", k), wb_if.dst_addr, sb_addr.pop_front());
                check($sformatf("drain%0d_dst", k),      wb_if.dst,      sb_data.pop_front());
            end
            check("drain_left", 32'(sb_addr.size()), 0);
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0);
            #1;
            check("drain_empty", wb_if.empty, 1);
        end

        // Pointer wrap: ten single results retire in order one cycle later.
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            if (i < 10) drive(1, 7, 16'h0010 + 16'(i), 0, 0, 0);
            else        drive(0, 0, 0, 0, 0, 0);
            #1;
            if (i > 0) begin
                check($sformatf("wrap%0d_we", i),       wb_if.we,       1);
                check($sformatf("wrap%0d_dst_addr", i), wb_if.dst_addr, 7);
                check($sformatf("wrap%0d_dst", i),      wb_if.dst,      16'h0010 + 16'(i - 1));
            end
        end

        // Asynchronous reset with three entries queued.
        @(negedge clk);
        drive(1, 1, 16'h00A1, 1, 2, 16'h00A2);
        @(negedge clk);
        drive(1, 3, 16'h00A3, 1, 4, 16'h00A4);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        wb_if.p0_addr = 2;
        #1;
        check("prerst_we", wb_if.we, 1);
        check("prerst_p0_hit", wb_if.p0_hit, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_we", wb_if.we, 0);
        check("rst_empty", wb_if.empty, 1);
        check("rst_p0_hit", wb_if.p0_hit, 0);
        check("rst_dst", wb_if.dst, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        drive(1, 9, 16'hABCD, 0, 0, 0);
        wb_if.p0_addr = 9;
        #1;
        check("postrst_empty", wb_if.empty, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check("postrst_we", wb_if.we, 1);
        check("postrst_dst_addr", wb_if.dst_addr, 9);
        check("postrst_dst", wb_if.dst, 16'hABCD);
        check("postrst_p0_byp", wb_if.p0_byp, 16'hABCD);
        @(negedge clk);
        #1;
        check("postrst_drained", wb_if.empty, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
